uart_tx_arbiter: RTL and testbench

//  Shares one UART_TX serializer between NUM_REQ byte-stream requesters.
//  - Round-robin arbitration at packet granularity; a packet is a run of bytes ending in req_last.
//  - Feeds UART_TX one byte at a time via flag_tx/TX_Byte and tracks its Busy output.
//  - Sits between the protocol/debug sources and the single UART_TX instance.

---
 rtl/uart_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART_TX serializer between NUM_REQ byte-stream requesters.
//   Arbitration is round-robin at packet granularity (a packet ends with a
//   byte flagged req_last). One byte is in flight at a time; no FIFO.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_last    per-channel byte valid / last-of-packet
//   req_data              packed byte lanes, lane i = req_data[8i+7:8i]
//   req_ready             byte on channel i accepted this cycle
//   grant                 one-hot owner of the serializer, 0 when free
//   flag_tx, tx_byte      to UART_TX (start pulse / byte to send)
//   tx_busy               from UART_TX Busy
//   pkt_done              1-cycle pulse when a packet's last byte is sent
//   tx_err                sticky: tx_busy never rose after flag_tx
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 flag_tx,
  output logic [7:0]           tx_byte,
  input  logic                 tx_busy,
  output logic                 pkt_done,
  output logic                 tx_err
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW   = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW   = $clog2(GAP_CYCLES + 2);
  localparam int GLIM = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_e;

  state_e        state_q, state_d;
  // rr_q doubles as the owner index while own_q is set: the pointer always
  // takes the granted channel, so no separate grant index is stored.
  logic [IW-1:0] rr_q, rr_d;
  logic          own_q, own_d;
  logic [7:0]    byte_q, byte_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          err_q, err_d;

  // round-robin pick: lowest valid index above the pointer, else lowest overall
  logic          pick_vld, hi_vld;
  logic [IW-1:0] pick_idx, hi_idx;
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    hi_vld   = 1'b0;
    hi_idx   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(i);
      end
      if (req_valid[i] && (IW'(i) > rr_q)) begin
        hi_vld = 1'b1;
        hi_idx = IW'(i);
      end
    end
    if (hi_vld) pick_idx = hi_idx;
  end

  // owner's lane
  logic       lane_vld, lane_last;
  logic [7:0] lane_data;
  always_comb begin
    lane_vld  = 1'b0;
    lane_last = 1'b0;
    lane_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_q == IW'(i)) begin
        lane_vld  = req_valid[i];
        lane_last = req_last[i];
        lane_data = req_data[8*i +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign grant[g] = own_q && (rr_q == IW'(g));
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= IW'(NUM_REQ-1);
      own_q   <= 1'b0;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    byte_d  = byte_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        // tx_busy gate also covers a reset taken while UART_TX is mid-frame
        if (!tx_busy && pick_vld) begin
          rr_d    = pick_idx;
          own_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (lane_vld) begin
          byte_d  = lane_data;
          last_d  = lane_last;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT-1)) begin
          // serializer never answered: drop the packet
          err_d   = 1'b1;
          own_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            own_d   = 1'b0;
            gap_d   = '0;
            state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GLIM)) state_d = S_IDLE;
        else                    gap_d   = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    flag_tx   = (state_q == S_SEND);
    pkt_done  = (state_q == S_WAIT_DONE) && !tx_busy && last_q;
    req_ready = grant & {NUM_REQ{state_q == S_FETCH}};
    tx_byte   = byte_q;
    tx_err    = err_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int BT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] rv [2], rl [2], rdy [2], gnt [2];
  logic [8*NR-1:0] rd [2];
  logic          flag [2], busy [2], done [2], err [2];
  logic [7:0]    txb [2];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(0), .BUSY_TIMEOUT(BT)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_last(rl[0]), .req_data(rd[0]),
    .req_ready(rdy[0]), .grant(gnt[0]), .flag_tx(flag[0]), .tx_byte(txb[0]),
    .tx_busy(busy[0]), .pkt_done(done[0]), .tx_err(err[0]));

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(5), .BUSY_TIMEOUT(BT)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_last(rl[1]), .req_data(rd[1]),
    .req_ready(rdy[1]), .grant(gnt[1]), .flag_tx(flag[1]), .tx_byte(txb[1]),
    .tx_busy(busy[1]), .pkt_done(done[1]), .tx_err(err[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // requester queues {last,byte}, index d*NR+ch
  logic [8:0] chq [8][$];
  int         pause_ctr [8];
  bit         pause_arm [8];
  // UART stub per DUT
  bit         stub_en [2], busy_s [2], force_busy [2];
  logic [9:0] sh [2], frame_log [2];
  int         scnt [2];
  // monitors
  logic [7:0] obs [2][$];
  int         flag_cyc [2][$], done_cyc [2][$], gnt_cyc [2][$];
  int         err_cyc [2], nflag [2];
  logic [NR-1:0] gnt_or [2], prev_gnt [2];
  logic       prev_err [2];

  task automatic refresh();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) begin
        int k = d*NR + i;
        if (chq[k].size() > 0 && pause_ctr[k] == 0) begin
          rv[d][i] = 1'b1;
          rl[d][i] = chq[k][0][8];
          rd[d][8*i +: 8] = chq[k][0][7:0];
        end else begin
          rv[d][i] = 1'b0;
          rl[d][i] = 1'b0;
          rd[d][8*i +: 8] = 8'h00;
        end
      end
  endtask

  task automatic load(input int d, input int ch, input logic [7:0] b, input logic last);
    chq[d*NR+ch].push_back({last, b});
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      obs[d].delete(); flag_cyc[d].delete(); done_cyc[d].delete(); gnt_cyc[d].delete();
      err_cyc[d] = -1; nflag[d] = 0; gnt_or[d] = '0;
    end
  endtask

  task automatic step();
    logic [NR-1:0] acc [2];
    logic fl [2];
    logic [7:0] fb [2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      acc[d] = rdy[d] & rv[d];
      fl[d]  = flag[d];
      fb[d]  = txb[d];
      if (flag[d]) begin obs[d].push_back(txb[d]); flag_cyc[d].push_back(cyc); nflag[d]++; end
      if (done[d]) done_cyc[d].push_back(cyc);
      if (gnt[d] != '0 && prev_gnt[d] == '0) gnt_cyc[d].push_back(cyc);
      prev_gnt[d] = gnt[d];
      gnt_or[d]   = gnt_or[d] | gnt[d];
      if (err[d] && !prev_err[d]) err_cyc[d] = cyc;
      prev_err[d] = err[d];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (fl[d] && stub_en[d]) begin
        busy_s[d] = 1'b1;
        sh[d]     = {1'b1, fb[d], 1'b0};
        scnt[d]   = 10;
      end else if (scnt[d] > 0) begin
        frame_log[d] = {sh[d][0], frame_log[d][9:1]};
        sh[d] = sh[d] >> 1;
        scnt[d]--;
        if (scnt[d] == 0) busy_s[d] = 1'b0;
      end
      busy[d] = busy_s[d] | force_busy[d];
      for (int i = 0; i < NR; i++) begin
        int k = d*NR + i;
        if (acc[d][i]) begin
          void'(chq[k].pop_front());
          if (pause_arm[k]) begin pause_arm[k] = 1'b0; pause_ctr[k] = 50; end
        end else if (pause_ctr[k] > 0) begin
          pause_ctr[k]--;
        end
      end
    end
    refresh();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_idle(input int budget, input string name);
    int n = 0;
    bit idle = 1'b0;
    while (!idle && n < budget) begin
      step();
      n++;
      idle = 1'b1;
      for (int k = 0; k < 2*NR; k++) if (chq[k].size() != 0) idle = 1'b0;
      for (int d = 0; d < 2; d++) if (gnt[d] != '0 || busy[d]) idle = 1'b0;
    end
    checks++;
    if (!idle) begin errors++; $display("FAIL %s_idle: still busy after %0d cycles", name, budget); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run(2);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({gnt[d], rdy[d], flag[d], txb[d], done[d], err[d]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: grant=%b ready=%b flag=%b byte=%h done=%b err=%b want all 0",
                 d, gnt[d], rdy[d], flag[d], txb[d], done[d], err[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    clear_logs();
    load(0, 0, 8'hA5, 1'b1);
    refresh();
    run(1);
    checks++;
    if (gnt[0] !== 4'b0001 || rdy[0] !== 4'b0001 || flag[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_fetch: grant=%b ready=%b flag=%b want 0001 0001 0", gnt[0], rdy[0], flag[0]);
    end
    run(1);
    checks++;
    if (flag[0] !== 1'b1 || txb[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_send: flag=%b byte=%h want 1 a5", flag[0], txb[0]);
    end
    run_idle(100, "single");
    checks++;
    if (frame_log[0] !== 10'b1101001010) begin
      errors++;
      $display("FAIL single_frame: got %b want 1101001010", frame_log[0]);
    end
    checks++;
    if (done_cyc[0].size() != 1 || gnt[0] !== 4'b0000) begin
      errors++;
      $display("FAIL single_done: pkt_done pulses=%0d grant=%b want 1 0000", done_cyc[0].size(), gnt[0]);
    end
  endtask

  task automatic test_rr();
    logic [31:0] got;
    int dg;
    clear_logs();
    load(0, 1, 8'h11, 1'b0); load(0, 1, 8'h12, 1'b1);
    load(0, 2, 8'h21, 1'b0); load(0, 2, 8'h22, 1'b1);
    refresh();
    run_idle(300, "rr_pair");
    got = '0;
    foreach (obs[0][i]) got = {got[23:0], obs[0][i]};
    checks++;
    if (obs[0].size() != 4 || got !== 32'h11122122) begin
      errors++;
      $display("FAIL rr_pair_order: got %0d bytes %h want 4 bytes 11122122", obs[0].size(), got);
    end
    dg = (gnt_cyc[0].size() >= 2 && done_cyc[0].size() >= 1) ? gnt_cyc[0][1] - done_cyc[0][0] : -1;
    checks++;
    if (dg != 2) begin
      errors++;
      $display("FAIL rr_nogap: done-to-grant %0d cycles want 2", dg);
    end
    clear_logs();
    load(0, 0, 8'h03, 1'b1); load(0, 1, 8'h13, 1'b1);
    load(0, 2, 8'h23, 1'b1); load(0, 3, 8'h33, 1'b1);
    refresh();
    run_idle(300, "rr_all");
    got = '0;
    foreach (obs[0][i]) got = {got[23:0], obs[0][i]};
    checks++;
    if (obs[0].size() != 4 || got !== 32'h33031323) begin
      errors++;
      $display("FAIL rr_all_order: got %0d bytes %h want 4 bytes 33031323", obs[0].size(), got);
    end
  endtask

  task automatic test_stall();
    logic [31:0] got;
    clear_logs();
    pause_arm[0] = 1'b1;
    load(0, 0, 8'h41, 1'b0); load(0, 0, 8'h42, 1'b0); load(0, 0, 8'h43, 1'b1);
    refresh();
    run(4);
    checks++;
    if (obs[0].size() != 1 || gnt[0] !== 4'b0001) begin
      errors++;
      $display("FAIL stall_first: sent %0d bytes grant=%b want 1 0001", obs[0].size(), gnt[0]);
    end
    load(0, 3, 8'h4F, 1'b1);
    refresh();
    nflag[0] = 0; gnt_or[0] = '0;
    run(30);
    checks++;
    if (nflag[0] != 0 || gnt_or[0] !== 4'b0001) begin
      errors++;
      $display("FAIL stall_hold: flag pulses=%0d grants seen=%b want 0 0001", nflag[0], gnt_or[0]);
    end
    run_idle(400, "stall");
    got = '0;
    foreach (obs[0][i]) got = {got[23:0], obs[0][i]};
    checks++;
    if (obs[0].size() != 4 || got !== 32'h4142434F) begin
      errors++;
      $display("FAIL stall_order: got %0d bytes %h want 4 bytes 4142434f", obs[0].size(), got);
    end
  endtask

  task automatic test_timeout();
    int dt;
    checks++;
    if (err[0] !== 1'b0) begin errors++; $display("FAIL timeout_pre: tx_err=%b want 0", err[0]); end
    clear_logs();
    stub_en[0] = 1'b0;
    load(0, 1, 8'h77, 1'b1);
    refresh();
    run(20);
    dt = (flag_cyc[0].size() >= 1 && err_cyc[0] >= 0) ? err_cyc[0] - flag_cyc[0][0] : -1;
    checks++;
    if (dt != BT + 1) begin
      errors++;
      $display("FAIL timeout_delay: flag-to-err %0d cycles want %0d", dt, BT + 1);
    end
    checks++;
    if (err[0] !== 1'b1 || gnt[0] !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_drop: tx_err=%b grant=%b want 1 0000", err[0], gnt[0]);
    end
    run(20);
    checks++;
    if (err[0] !== 1'b1) begin errors++; $display("FAIL timeout_sticky: tx_err=%b want 1", err[0]); end
    stub_en[0] = 1'b1;
  endtask

  task automatic test_reset_busy();
    logic [15:0] got;
    clear_logs();
    load(0, 2, 8'h55, 1'b1);
    refresh();
    run(6);
    force_busy[0] = 1'b1;
    busy[0] = 1'b1;
    load(0, 0, 8'h65, 1'b1); load(0, 1, 8'h66, 1'b1);
    refresh();
    run(2);
    checks++;
    if (gnt[0] !== 4'b0100 || txb[0] !== 8'h55) begin
      errors++;
      $display("FAIL rstbusy_pre: grant=%b byte=%h want 0100 55", gnt[0], txb[0]);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({gnt[0], rdy[0], flag[0], txb[0], done[0], err[0]} !== '0) begin
      errors++;
      $display("FAIL rstbusy_async: grant=%b ready=%b flag=%b byte=%h done=%b err=%b want all 0",
               gnt[0], rdy[0], flag[0], txb[0], done[0], err[0]);
    end
    #1;
    rst_n = 1'b1;
    clear_logs();
    run(15);
    checks++;
    if (gnt_or[0] !== 4'b0000) begin
      errors++;
      $display("FAIL rstbusy_hold: grants seen=%b want 0000 while busy", gnt_or[0]);
    end
    force_busy[0] = 1'b0;
    busy[0] = busy_s[0];
    run_idle(200, "rstbusy");
    got = '0;
    foreach (obs[0][i]) got = {got[7:0], obs[0][i]};
    checks++;
    if (obs[0].size() != 2 || got !== 16'h6566) begin
      errors++;
      $display("FAIL rstbusy_order: got %0d bytes %h want 2 bytes 6566", obs[0].size(), got);
    end
  endtask

  task automatic test_gap();
    logic [15:0] got;
    int dg;
    clear_logs();
    load(1, 0, 8'h61, 1'b1); load(1, 1, 8'h62, 1'b1);
    refresh();
    run_idle(300, "gap");
    got = '0;
    foreach (obs[1][i]) got = {got[7:0], obs[1][i]};
    checks++;
    if (obs[1].size() != 2 || got !== 16'h6162) begin
      errors++;
      $display("FAIL gap_order: got %0d bytes %h want 2 bytes 6162", obs[1].size(), got);
    end
    dg = (gnt_cyc[1].size() >= 2 && done_cyc[1].size() >= 1) ? gnt_cyc[1][1] - done_cyc[1][0] : -1;
    checks++;
    if (dg != 7) begin
      errors++;
      $display("FAIL gap_spacing: done-to-grant %0d cycles want 7", dg);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rv[d] = '0; rl[d] = '0; rd[d] = '0; busy[d] = 1'b0;
      stub_en[d] = 1'b1; busy_s[d] = 1'b0; force_busy[d] = 1'b0;
      sh[d] = '0; frame_log[d] = '0; scnt[d] = 0;
      prev_gnt[d] = '0; prev_err[d] = 1'b0;
    end
    for (int k = 0; k < 2*NR; k++) begin pause_ctr[k] = 0; pause_arm[k] = 1'b0; end
    clear_logs();
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_timeout();
    test_reset_busy();
    test_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
